// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and port-owner encodings
// plus the grant decision helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam int WD_CNT_W = 16;

    // Data side wins unless fetch is waiting and data has used up its streak allowance.
    function automatic arb_owner_e pick_owner(input logic if_req,
                                              input logic dm_req,
                                              input logic streak_full);
        return (if_req && (!dm_req || streak_full)) ? OWN_I : OWN_D;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM stage buffers, the arbiter and the memory macro.
// MEM_ARB_PERF_EN adds the three performance counter outputs.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;

    logic                  dm_req;
    logic                  dm_we;
    logic [DATA_W/8-1:0]   dm_be;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  dm_ready;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_valid;
    logic                  err;

`ifdef MEM_ARB_PERF_EN
    logic [31:0]           perf_i_grants;
    logic [31:0]           perf_d_grants;
    logic [31:0]           perf_conflicts;
`endif

    // Arbiter view: stage requests and memory responses come in, everything else goes out.
    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata, mem_valid,
        output if_rdata, if_ready,
        output dm_rdata, dm_ready,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output err
`ifdef MEM_ARB_PERF_EN
        , output perf_i_grants, perf_d_grants, perf_conflicts
`endif
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata, mem_valid,
        input  if_rdata, if_ready,
        input  dm_rdata, dm_ready,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  err
`ifdef MEM_ARB_PERF_EN
        , input perf_i_grants, perf_d_grants, perf_conflicts
`endif
    );

endinterface

// File: rtl/arb_watchdog.sv
// Response watchdog for the memory arbiter: cleared on issue, counts while waiting,
// flags expiry on the cycle the count would reach TIMEOUT.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    logic [WD_CNT_W-1:0] count_reg;
    logic [WD_CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_en) begin
            count_next = count_reg + WD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Fires in the TIMEOUT-th waiting cycle so the abort lands exactly TIMEOUT cycles after issue+1.
    assign expire = count_en && (count_reg == WD_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between fetch (I) and data (D) with D priority,
// fetch anti-starvation streak limit and a response watchdog. MEM_ARB_PERF_EN adds perf counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    arb_state_e            state_reg, state_next;
    arb_owner_e            owner_reg, owner_next;
    arb_owner_e            grant_owner;

    logic [STREAK_W-1:0]   streak_reg, streak_next;
    logic                  mem_req_reg, mem_req_next;
    logic                  mem_we_reg, mem_we_next;
    logic [BE_W-1:0]       mem_be_reg, mem_be_next;
    logic [ADDR_W-1:0]     mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]     mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0]     if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0]     dm_rdata_reg, dm_rdata_next;
    logic                  if_ready_reg, if_ready_next;
    logic                  dm_ready_reg, dm_ready_next;
    logic                  err_reg, err_next;

    logic                  any_req;
    logic                  streak_full;
    logic                  wd_expire;
    logic                  wd_clear;
    logic                  wd_count_en;
    logic                  resp_done;
    logic [DATA_W-1:0]     resp_data;

    assign any_req     = bus.if_req | bus.dm_req;
    assign streak_full = (streak_reg == STREAK_W'(MAX_D_STREAK));
    assign grant_owner = pick_owner(bus.if_req, bus.dm_req, streak_full);
    assign wd_clear    = (state_reg == ST_ISSUE);
    assign wd_count_en = (state_reg == ST_WAIT);

    // A real response takes precedence over an expiry in the same cycle.
    assign resp_done = bus.mem_valid | wd_expire;
    assign resp_data = bus.mem_valid ? bus.mem_rdata : '0;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_arb_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expire   (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (any_req)   state_next = ST_ISSUE;
            ST_ISSUE:                state_next = ST_WAIT;
            ST_WAIT:  if (resp_done) state_next = ST_DONE;
            ST_DONE:                 state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Next values of every registered output; pulses default low, data holds.
    always_comb begin
        owner_next     = owner_reg;
        streak_next    = streak_reg;
        mem_req_next   = 1'b0;
        mem_we_next    = mem_we_reg;
        mem_be_next    = mem_be_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        if_ready_next  = 1'b0;
        dm_ready_next  = 1'b0;
        err_next       = 1'b0;

        if (state_reg == ST_IDLE && any_req) begin
            owner_next   = grant_owner;
            mem_req_next = 1'b1;
            if (grant_owner == OWN_I) begin
                mem_we_next    = 1'b0;
                mem_be_next    = '1;
                mem_addr_next  = bus.if_addr;
                mem_wdata_next = '0;
                streak_next    = '0;
            end else begin
                mem_we_next    = bus.dm_we;
                mem_be_next    = bus.dm_be;
                mem_addr_next  = bus.dm_addr;
                mem_wdata_next = bus.dm_wdata;
                if (!bus.if_req) begin
                    streak_next = '0;
                end else if (!streak_full) begin
                    streak_next = streak_reg + STREAK_W'(1);
                end
            end
        end

        if (state_reg == ST_WAIT && resp_done) begin
            err_next = ~bus.mem_valid;
            if (owner_reg == OWN_I) begin
                if_rdata_next = resp_data;
                if_ready_next = 1'b1;
            end else begin
                dm_rdata_next = resp_data;
                dm_ready_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg     <= OWN_I;
            streak_reg    <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            if_ready_reg  <= 1'b0;
            dm_ready_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            owner_reg     <= owner_next;
            streak_reg    <= streak_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_be_reg    <= mem_be_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
            if_ready_reg  <= if_ready_next;
            dm_ready_reg  <= dm_ready_next;
            err_reg       <= err_next;
        end
    end

    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_be    = mem_be_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.dm_rdata  = dm_rdata_reg;
    assign bus.if_ready  = if_ready_reg;
    assign bus.dm_ready  = dm_ready_reg;
    assign bus.err       = err_reg;

`ifdef MEM_ARB_PERF_EN
    // Index 0: fetch grants, 1: data grants, 2: IDLE cycles with both stages requesting.
    logic [2:0] perf_inc;

    assign perf_inc[0] = (state_reg == ST_IDLE) && any_req && (grant_owner == OWN_I);
    assign perf_inc[1] = (state_reg == ST_IDLE) && any_req && (grant_owner == OWN_D);
    assign perf_inc[2] = (state_reg == ST_IDLE) && bus.if_req && bus.dm_req;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign bus.perf_i_grants  = g_perf[0].cnt_reg;
    assign bus.perf_d_grants  = g_perf[1].cnt_reg;
    assign bus.perf_conflicts = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected memory strobes and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_D_STREAK (4),
        .TIMEOUT      (255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } rsp_exp_t;

    mem_exp_t    mem_q[$];
    rsp_exp_t    rsp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] hold_if = 32'h0;
    logic [31:0] hold_dm = 32'h0;
    logic        mem_respond = 1'b1;
    logic [31:0] mem_data = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   64'(bus.mem_req),   64'd0);
        check({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
        check({tag, "_mem_be"},    64'(bus.mem_be),    64'd0);
        check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_if_rdata"},  64'(bus.if_rdata),  64'd0);
        check({tag, "_dm_rdata"},  64'(bus.dm_rdata),  64'd0);
        check({tag, "_if_ready"},  64'(bus.if_ready),  64'd0);
        check({tag, "_dm_ready"},  64'(bus.dm_ready),  64'd0);
        check({tag, "_err"},       64'(bus.err),       64'd0);
    endtask

    // Single request from an idle arbiter; called one step after a posedge in an IDLE cycle.
    // Fetch goes out as a read with all byte lanes; completion is 3 cycles later, or 257 on timeout.
    task automatic issue(input logic is_d, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic respond, input logic [31:0] rdata);
        int       c0;
        int       lat;
        mem_exp_t me;
        rsp_exp_t re;
        c0 = cyc;
        lat = respond ? 3 : 257;
        mem_respond = respond;
        mem_data = rdata;
        me.cyc = c0 + 1;
        me.addr = addr;
        me.we = is_d ? we : 1'b0;
        me.be = is_d ? be : 4'hF;
        me.wdata = wdata;
        me.chk_wdata = is_d;
        mem_q.push_back(me);
        re.cyc = c0 + lat;
        re.is_d = is_d;
        re.rdata = respond ? rdata : 32'h0;
        re.err = ~respond;
        rsp_q.push_back(re);
        if (is_d) begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_be = be;
            bus.dm_addr = addr; bus.dm_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        repeat (lat) tick();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        tick();
    endtask

    // Memory model: answers one cycle after the strobe when enabled.
    initial begin : mem_model
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req && mem_respond) begin
                @(posedge clk);
                #1 bus.mem_valid = 1'b1; bus.mem_rdata = mem_data;
                @(posedge clk);
                #1 bus.mem_valid = 1'b0; bus.mem_rdata = 32'h0;
            end
        end
    end

    initial begin : monitor
        mem_exp_t me;
        rsp_exp_t re;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.mem_req) begin
                    if (mem_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL mem_req_unexpected: got mem_req=1 at cycle %0d, required none", cyc);
                    end else begin
                        me = mem_q.pop_front();
                        check("mem_req_cycle", 64'(cyc),          64'(me.cyc));
                        check("mem_addr",      64'(bus.mem_addr), 64'(me.addr));
                        check("mem_we",        64'(bus.mem_we),   64'(me.we));
                        check("mem_be",        64'(bus.mem_be),   64'(me.be));
                        if (me.chk_wdata) check("mem_wdata", 64'(bus.mem_wdata), 64'(me.wdata));
                    end
                end
                if (bus.if_ready && bus.dm_ready) begin
                    n_vec++; n_fail++;
                    $display("FAIL both_ready: got if_ready=1 dm_ready=1 at cycle %0d, required at most one", cyc);
                end else if (bus.if_ready || bus.dm_ready) begin
                    if (rsp_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL ready_unexpected: got ready at cycle %0d, required none", cyc);
                    end else begin
                        re = rsp_q.pop_front();
                        check("rsp_port_is_d", 64'(bus.dm_ready), 64'(re.is_d));
                        check("rsp_cycle",     64'(cyc),          64'(re.cyc));
                        check("rsp_err",       64'(bus.err),      64'(re.err));
                        if (bus.dm_ready) begin
                            check("dm_rdata",      64'(bus.dm_rdata), 64'(re.rdata));
                            check("if_rdata_hold", 64'(bus.if_rdata), 64'(hold_if));
                            hold_dm = re.rdata;
                        end else begin
                            check("if_rdata",      64'(bus.if_rdata), 64'(re.rdata));
                            check("dm_rdata_hold", 64'(bus.dm_rdata), 64'(hold_dm));
                            hold_if = re.rdata;
                        end
                    end
                end else if (bus.err) begin
                    n_vec++; n_fail++;
                    $display("FAIL err_without_ready: got err=1 at cycle %0d, required err only with ready", cyc);
                end
            end
        end
    end

    initial begin : guard
        #100000;
        $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        mem_exp_t    me;
        rsp_exp_t    re;
        logic [9:0]  order;
        int          c0;
`ifdef MEM_ARB_PERF_EN
        logic [31:0] p_i0, p_d0, p_c0;
`endif
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'h0;
        bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;

        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Fetch read, then a store, then a partial-lane load.
        issue(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF);
        issue(1'b1, 1'b1, 4'hF, 32'h0000_2000, 32'h1234_5678, 1'b1, 32'h5555_AAAA);
        issue(1'b1, 1'b0, 4'h3, 32'h0000_2004, 32'hFFFF_0000, 1'b1, 32'h0BAD_F00D);

        // Stray memory response while idle must not complete anything.
        bus.mem_valid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_valid = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) tick();
        check("stray_valid_if_rdata", 64'(bus.if_rdata), 64'(hold_if));
        check("stray_valid_dm_rdata", 64'(bus.dm_rdata), 64'(hold_dm));

        // Both stages request continuously: D,D,D,D,I,D,D,D,D,I (bit set = fetch).
        order = 10'b10_0001_0000;
        mem_respond = 1'b1;
        mem_data = 32'hCAFE_F00D;
        c0 = cyc;
`ifdef MEM_ARB_PERF_EN
        p_i0 = bus.perf_i_grants; p_d0 = bus.perf_d_grants; p_c0 = bus.perf_conflicts;
`endif
        for (int i = 0; i < 10; i++) begin
            me.cyc = c0 + 1 + 4 * i;
            me.addr = order[i] ? 32'h0000_0400 : 32'h0000_3000;
            me.we = 1'b0;
            me.be = order[i] ? 4'hF : 4'h3;
            me.wdata = 32'h0;
            me.chk_wdata = ~order[i];
            mem_q.push_back(me);
            re.cyc = c0 + 3 + 4 * i;
            re.is_d = ~order[i];
            re.rdata = 32'hCAFE_F00D;
            re.err = 1'b0;
            rsp_q.push_back(re);
        end
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'h3;
        bus.dm_addr = 32'h0000_3000; bus.dm_wdata = 32'h0;
        repeat (39) tick();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        repeat (2) tick();
`ifdef MEM_ARB_PERF_EN
        check("perf_conflicts", 64'(bus.perf_conflicts - p_c0), 64'd10);
        check("perf_i_grants",  64'(bus.perf_i_grants - p_i0),  64'd2);
        check("perf_d_grants",  64'(bus.perf_d_grants - p_d0),  64'd8);
`endif

        // Memory never answers: abort with err and zero data, then normal service resumes.
        issue(1'b1, 1'b0, 4'hF, 32'h0000_2008, 32'h0, 1'b0, 32'h0);
        issue(1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b1, 32'h1357_9BDF);

        // Reset while waiting for memory: outputs clear at once, the late response is ignored.
        mem_respond = 1'b0;
        c0 = cyc;
        me.cyc = c0 + 1; me.addr = 32'h0000_0108; me.we = 1'b0;
        me.be = 4'hF; me.wdata = 32'h0; me.chk_wdata = 1'b0;
        mem_q.push_back(me);
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0108;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_wait");
        hold_if = 32'h0;
        hold_dm = 32'h0;
        bus.if_req = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_valid = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) tick();
        check("late_valid_if_rdata", 64'(bus.if_rdata), 64'd0);
        check("late_valid_if_ready", 64'(bus.if_ready), 64'd0);

        issue(1'b1, 1'b1, 4'b0101, 32'h0000_200C, 32'hA5A5_A5A5, 1'b1, 32'h2468_ACE0);

        repeat (5) tick();
        check("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
